// File: rtl/dispatch_pkg.sv
// Shared dispatch definitions: ROB sizing defaults, dispatch FSM states and
// the decoder op-class encodings used across the core.
package dispatch_pkg;

    localparam int unsigned ROB_WIDTH = 4;
    localparam int unsigned ROB_SIZE  = 1 << ROB_WIDTH;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } disp_state_e;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_LOAD   = 3'd2,
        OP_STORE  = 3'd3,
        OP_JUMP   = 3'd4,
        OP_SYS    = 3'd5
    } dec_op_e;

endpackage

// File: rtl/credit_counter.sv
// Up/down occupancy counter with full flag.
//   clk_in, rst_in : clock, async active-low reset
//   en             : global enable, low holds the count
//   clr            : synchronous clear, wins over inc/dec
//   inc, dec       : one-entry allocate / release
//   count          : occupied entries (registered)
//   full_c         : count == MAX (combinational from count)
// A release at zero is dropped; simultaneous inc and dec cancel.
module credit_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned CW  = $clog2(MAX) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          en,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full_c
);

    logic dec_ok_c;

    assign dec_ok_c = dec && (count != '0);
    assign full_c   = (count == CW'(MAX));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
        end else if (en) begin
            if (clr) begin
                count <= '0;
            end else if (inc && !dec_ok_c) begin
                count <= count + CW'(1);
            end else if (dec_ok_c && !inc) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: allocates ROB tags in order, tracks ROB/RS/LSB
// occupancy, handshakes decoded instructions into the back-end and
// sequences the flush after a mispredict clear.
//   clk_in, rst_in, rdy_in : clock, async active-low reset, global enable
//   clear                  : mispredict flush request
//   dec_valid/need_rs/lsb  : decoder request and its resource needs
//   dec_ready              : combinational accept
//   issue_valid/tag/rs/lsb : registered issue record, one cycle after accept
//   rob_commit, rs_release, lsb_release : back-end frees
//   rob_count/rs_count/lsb_count        : occupancy
//   flushing               : high while in FLUSH
// Optional macro DISPATCH_PERF_EN adds saturating perf_issued / perf_stall.
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int unsigned ROB_WIDTH    = dispatch_pkg::ROB_WIDTH,
    parameter int unsigned ROB_SIZE     = dispatch_pkg::ROB_SIZE,
    parameter int unsigned RS_SIZE      = 8,
    parameter int unsigned LSB_SIZE     = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear,
    input  logic                        dec_valid,
    input  logic                        dec_need_rs,
    input  logic                        dec_need_lsb,
    output logic                        dec_ready,
    output logic                        issue_valid,
    output logic [ROB_WIDTH-1:0]        issue_tag,
    output logic                        issue_rs,
    output logic                        issue_lsb,
    input  logic                        rob_commit,
    input  logic                        rs_release,
    input  logic                        lsb_release,
    output logic [ROB_WIDTH:0]          rob_count,
    output logic [$clog2(RS_SIZE):0]    rs_count,
    output logic [$clog2(LSB_SIZE):0]   lsb_count,
    output logic                        flushing
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]                 perf_issued,
    output logic [31:0]                 perf_stall
`endif
);

    localparam int unsigned FCW = $clog2(FLUSH_CYCLES) + 1;

    disp_state_e          state;
    logic [FCW-1:0]       flush_cnt;
    logic [ROB_WIDTH-1:0] tail;
    logic                 in_run_c;
    logic                 fire_c;
    logic                 rob_full_c;
    logic                 rs_full_c;
    logic                 lsb_full_c;

    assign in_run_c  = (state == RUN);
    assign dec_ready = rdy_in && in_run_c && !clear && !rob_full_c
                    && (!dec_need_rs  || !rs_full_c)
                    && (!dec_need_lsb || !lsb_full_c);
    assign fire_c    = dec_valid && dec_ready;

    // Flush sequencer; a clear at any time (re)loads the countdown.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= RUN;
            flush_cnt <= '0;
            flushing  <= 1'b0;
        end else if (rdy_in) begin
            if (clear) begin
                state     <= FLUSH;
                flush_cnt <= FCW'(FLUSH_CYCLES - 1);
                flushing  <= 1'b1;
            end else if (state == FLUSH) begin
                if (flush_cnt == '0) begin
                    state    <= RUN;
                    flushing <= 1'b0;
                end else begin
                    flush_cnt <= flush_cnt - FCW'(1);
                end
            end
        end
    end

    // Tag allocation and the registered issue record.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tail        <= '0;
            issue_valid <= 1'b0;
            issue_tag   <= '0;
            issue_rs    <= 1'b0;
            issue_lsb   <= 1'b0;
        end else if (rdy_in) begin
            if (clear) begin
                tail        <= '0;
                issue_valid <= 1'b0;
            end else begin
                issue_valid <= fire_c;
                if (fire_c) begin
                    issue_tag <= tail;
                    issue_rs  <= dec_need_rs;
                    issue_lsb <= dec_need_lsb;
                    tail      <= tail + ROB_WIDTH'(1);
                end
            end
        end
    end

    // Frees are only honoured in RUN; during FLUSH everything is being dropped.
    credit_counter #(.MAX(ROB_SIZE), .CW(ROB_WIDTH + 1)) u_rob_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in),
        .clr    (clear),
        .inc    (fire_c),
        .dec    (rob_commit && in_run_c),
        .count  (rob_count),
        .full_c (rob_full_c)
    );

    credit_counter #(.MAX(RS_SIZE)) u_rs_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in),
        .clr    (clear),
        .inc    (fire_c && dec_need_rs),
        .dec    (rs_release && in_run_c),
        .count  (rs_count),
        .full_c (rs_full_c)
    );

    credit_counter #(.MAX(LSB_SIZE)) u_lsb_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in),
        .clr    (clear),
        .inc    (fire_c && dec_need_lsb),
        .dec    (lsb_release && in_run_c),
        .count  (lsb_count),
        .full_c (lsb_full_c)
    );

`ifdef DISPATCH_PERF_EN
    // Saturating performance counters; survive clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (fire_c && (perf_issued != '1)) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (rdy_in && in_run_c && dec_valid && !dec_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: a directed vector table followed by
// hand-written multi-cycle sequences (reset, fill, wrap, full+commit, flush,
// freeze).
module tb_dispatch_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic       clear;
    logic       dec_valid;
    logic       dec_need_rs;
    logic       dec_need_lsb;
    logic       dec_ready;
    logic       issue_valid;
    logic [3:0] issue_tag;
    logic       issue_rs;
    logic       issue_lsb;
    logic       rob_commit;
    logic       rs_release;
    logic       lsb_release;
    logic [4:0] rob_count;
    logic [3:0] rs_count;
    logic [3:0] lsb_count;
    logic       flushing;
`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk_in = ~clk_in;

    dispatch_ctrl dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear        (clear),
        .dec_valid    (dec_valid),
        .dec_need_rs  (dec_need_rs),
        .dec_need_lsb (dec_need_lsb),
        .dec_ready    (dec_ready),
        .issue_valid  (issue_valid),
        .issue_tag    (issue_tag),
        .issue_rs     (issue_rs),
        .issue_lsb    (issue_lsb),
        .rob_commit   (rob_commit),
        .rs_release   (rs_release),
        .lsb_release  (lsb_release),
        .rob_count    (rob_count),
        .rs_count     (rs_count),
        .lsb_count    (lsb_count),
        .flushing     (flushing)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_issued  (perf_issued),
        .perf_stall   (perf_stall)
`endif
    );

    typedef struct {
        logic       rdy, clr, valid, nrs, nlsb, commit, rsr, lsbr;
        logic       e_ready, e_iv;
        logic [3:0] e_tag;
        logic [4:0] e_rob;
        logic [3:0] e_rs, e_lsb;
        logic       e_fl;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, clr, valid, nrs, nlsb, commit, rsr, lsbr);
        rdy_in       = rdy;
        clear        = clr;
        dec_valid    = valid;
        dec_need_rs  = nrs;
        dec_need_lsb = nlsb;
        rob_commit   = commit;
        rs_release   = rsr;
        lsb_release  = lsbr;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one cycle of inputs, check the accept, then advance past the edge.
    task automatic step(input logic rdy, clr, valid, nrs, nlsb, commit, rsr, lsbr,
                        input logic exp_ready, input string name);
        drive(rdy, clr, valid, nrs, nlsb, commit, rsr, lsbr);
        #1;
        chk({name, ".dec_ready"}, 32'(dec_ready), 32'(exp_ready));
        tick();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    initial begin
        // rdy clr val nrs nlsb cmt rsr lsbr | ready iv tag rob rs lsb fl
        vecs[0]  = '{1,0,1,1,0,0,0,0, 1,1,4'd0,5'd1,4'd1,4'd0,0};
        vecs[1]  = '{1,0,1,0,1,0,0,0, 1,1,4'd1,5'd2,4'd1,4'd1,0};
        vecs[2]  = '{1,0,1,0,0,1,0,0, 1,1,4'd2,5'd2,4'd1,4'd1,0};
        vecs[3]  = '{1,0,0,0,0,0,1,1, 1,0,4'd0,5'd2,4'd0,4'd0,0};
        vecs[4]  = '{1,0,0,0,0,0,1,0, 1,0,4'd0,5'd2,4'd0,4'd0,0};
        vecs[5]  = '{1,0,1,1,1,1,0,0, 1,1,4'd3,5'd2,4'd1,4'd1,0};
        vecs[6]  = '{1,1,1,0,0,1,1,1, 0,0,4'd0,5'd0,4'd0,4'd0,1};
        vecs[7]  = '{1,0,1,0,0,1,1,1, 0,0,4'd0,5'd0,4'd0,4'd0,1};
        vecs[8]  = '{1,0,1,0,0,0,0,0, 0,0,4'd0,5'd0,4'd0,4'd0,0};
        vecs[9]  = '{1,0,1,1,0,0,0,0, 1,1,4'd0,5'd1,4'd1,4'd0,0};
        vecs[10] = '{0,0,1,0,0,1,1,0, 0,1,4'd0,5'd1,4'd1,4'd0,0};
        vecs[11] = '{1,0,1,0,0,1,1,0, 1,1,4'd1,5'd1,4'd0,4'd0,0};
        vecs[12] = '{1,1,0,0,0,0,0,0, 0,0,4'd0,5'd0,4'd0,4'd0,1};
        vecs[13] = '{1,1,0,0,0,0,0,0, 0,0,4'd0,5'd0,4'd0,4'd0,1};
        vecs[14] = '{1,0,0,0,0,0,0,0, 0,0,4'd0,5'd0,4'd0,4'd0,1};
        vecs[15] = '{1,0,1,0,0,0,0,0, 0,0,4'd0,5'd0,4'd0,4'd0,0};
        vecs[16] = '{1,0,1,0,0,0,0,0, 1,1,4'd0,5'd1,4'd0,4'd0,0};

        rst_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("rst.issue_valid", 32'(issue_valid), 0);
        chk("rst.issue_tag", 32'(issue_tag), 0);
        chk("rst.rob_count", 32'(rob_count), 0);
        chk("rst.rs_count", 32'(rs_count), 0);
        chk("rst.lsb_count", 32'(lsb_count), 0);
        chk("rst.flushing", 32'(flushing), 0);

        // Vector table
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rdy, vecs[i].clr, vecs[i].valid, vecs[i].nrs, vecs[i].nlsb,
                 vecs[i].commit, vecs[i].rsr, vecs[i].lsbr, vecs[i].e_ready,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
            if (vecs[i].e_iv)
                chk($sformatf("vec%0d.issue_tag", i), 32'(issue_tag), 32'(vecs[i].e_tag));
            chk($sformatf("vec%0d.rob_count", i), 32'(rob_count), 32'(vecs[i].e_rob));
            chk($sformatf("vec%0d.rs_count", i), 32'(rs_count), 32'(vecs[i].e_rs));
            chk($sformatf("vec%0d.lsb_count", i), 32'(lsb_count), 32'(vecs[i].e_lsb));
            chk($sformatf("vec%0d.flushing", i), 32'(flushing), 32'(vecs[i].e_fl));
        end

        // Async reset in the middle of an issue cycle
        drive(1, 0, 1, 1, 1, 0, 0, 0);
        #3;
        rst_in = 1'b0;
        #1;
        chk("arst.issue_valid", 32'(issue_valid), 0);
        chk("arst.issue_tag", 32'(issue_tag), 0);
        chk("arst.issue_rs", 32'(issue_rs), 0);
        chk("arst.issue_lsb", 32'(issue_lsb), 0);
        chk("arst.rob_count", 32'(rob_count), 0);
        chk("arst.rs_count", 32'(rs_count), 0);
        chk("arst.lsb_count", 32'(lsb_count), 0);
        chk("arst.flushing", 32'(flushing), 0);
        #2;
        rst_in = 1'b1;
        tick();
        chk("arst.first_valid", 32'(issue_valid), 1);
        chk("arst.first_tag", 32'(issue_tag), 0);
        chk("arst.first_rs", 32'(issue_rs), 1);
        chk("arst.first_lsb", 32'(issue_lsb), 1);

        // RS limits a back-to-back fill, then the ROB itself fills
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 1, 0, 0, 0, 0, 1, $sformatf("fill%0d", i));
            chk($sformatf("fill%0d.tag", i), 32'(issue_tag), 32'(i));
        end
        step(1, 0, 1, 1, 0, 0, 0, 0, 0, "rsfull");
        chk("rsfull.rs_count", 32'(rs_count), 8);
        chk("rsfull.issue_valid", 32'(issue_valid), 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 1, "rsrel");
        chk("rsrel.rs_count", 32'(rs_count), 7);
        step(1, 0, 1, 1, 0, 0, 0, 0, 1, "after_rel");
        chk("after_rel.tag", 32'(issue_tag), 8);
        chk("after_rel.rs_count", 32'(rs_count), 8);
        for (int i = 9; i < 16; i++) begin
            step(1, 0, 1, 0, 0, 0, 0, 0, 1, $sformatf("fill%0d", i));
            chk($sformatf("fill%0d.tag", i), 32'(issue_tag), 32'(i));
        end
        chk("robfull.rob_count", 32'(rob_count), 16);
        step(1, 0, 1, 0, 0, 1, 0, 0, 0, "full_commit");
        chk("full_commit.rob_count", 32'(rob_count), 15);
        chk("full_commit.issue_valid", 32'(issue_valid), 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, "refill");
        chk("refill.tag", 32'(issue_tag), 0);
        chk("refill.rob_count", 32'(rob_count), 16);

        // Issue plus commit at count 5 holds the count
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 1, "pre5");
        step(1, 0, 1, 0, 0, 1, 0, 0, 1, "iss_cmt");
        chk("iss_cmt.rob_count", 32'(rob_count), 5);
        chk("iss_cmt.tag", 32'(issue_tag), 5);

        // Tag wrap with immediate commits
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 0, 0, 0, 0, 0, 1, "wrap_iss");
            chk($sformatf("wrap%0d.tag", i), 32'(issue_tag), 32'(i));
            chk($sformatf("wrap%0d.rob_count", i), 32'(rob_count), 1);
            step(1, 0, 0, 0, 0, 1, 0, 0, 1, "wrap_cmt");
            chk($sformatf("wrap%0d.drain", i), 32'(rob_count), 0);
        end
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, "wrap_last");
        chk("wrap_last.tag", 32'(issue_tag), 0);

        // Flush from rob_count=7, rs_count=3
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0, 0, 0, 1, "fl_rs");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 1, "fl_nors");
        chk("fl_pre.rob_count", 32'(rob_count), 7);
        chk("fl_pre.rs_count", 32'(rs_count), 3);
        step(1, 1, 1, 1, 0, 1, 1, 0, 0, "fl_clear");
        chk("fl_clear.rob_count", 32'(rob_count), 0);
        chk("fl_clear.rs_count", 32'(rs_count), 0);
        chk("fl_clear.flushing", 32'(flushing), 1);
        chk("fl_clear.issue_valid", 32'(issue_valid), 0);
        step(1, 0, 1, 0, 0, 1, 1, 1, 0, "fl_c1");
        chk("fl_c1.flushing", 32'(flushing), 1);
        chk("fl_c1.rob_count", 32'(rob_count), 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, "fl_c2");
        chk("fl_c2.flushing", 32'(flushing), 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, "fl_resume");
        chk("fl_resume.tag", 32'(issue_tag), 0);
        chk("fl_resume.issue_valid", 32'(issue_valid), 1);

        // Freeze for three cycles mid-stream
        do_reset();
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, "fz_a");
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, "fz_b");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 1, 0, 0, 0, $sformatf("fz%0d", i));
            chk($sformatf("fz%0d.issue_valid", i), 32'(issue_valid), 1);
            chk($sformatf("fz%0d.tag", i), 32'(issue_tag), 1);
            chk($sformatf("fz%0d.rob_count", i), 32'(rob_count), 2);
        end
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, "fz_resume");
        chk("fz_resume.tag", 32'(issue_tag), 2);
        chk("fz_resume.rob_count", 32'(rob_count), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
Dispatch controller between the decoder and the back-end (ROB, RS, LSB). It tracks free ROB slots and RS/LSB occupancy, allocates ROB tags in order, and handshakes each decoded instruction into the back-end. It also sequences the pipeline flush on clear. It replaces decoder-local tag counting and the decoder's ad-hoc "has space" inputs.

Parameters:
ROB_WIDTH, 4, ROB tag width; ROB_SIZE = 2**ROB_WIDTH
ROB_SIZE, 16, ROB entries
RS_SIZE, 8, reservation-station entries
LSB_SIZE, 8, load/store-buffer entries
FLUSH_CYCLES, 2, cycles dec_ready is held low after clear (>=1)

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global enable; low freezes all state
clear  in  1  mispredict flush from ROB
dec_valid  in  1  decoder has an instruction
dec_need_rs  in  1  instruction needs an RS entry
dec_need_lsb  in  1  instruction needs an LSB entry
dec_ready  out  1  combinational accept; issue fires on dec_valid&dec_ready
issue_valid  out  1  registered: instruction issued last cycle
issue_tag  out  ROB_WIDTH  ROB tag of issued instruction
issue_rs  out  1  registered copy of dec_need_rs at issue
issue_lsb  out  1  registered copy of dec_need_lsb at issue
rob_commit  in  1  ROB head retired this cycle
rs_release  in  1  one RS entry freed
lsb_release  in  1  one LSB entry freed
rob_count  out  ROB_WIDTH+1  occupied ROB entries
rs_count  out  $clog2(RS_SIZE)+1  occupied RS entries
lsb_count  out  $clog2(LSB_SIZE)+1  occupied LSB entries
flushing  out  1  high while in FLUSH

Behaviour:
- Reset (rst_in=0, async): state RUN. tail/head=0. All counts 0. issue_valid/issue_rs/issue_lsb=0. issue_tag=0. flushing=0.
- FSM states: RUN, FLUSH.
  - RUN->FLUSH on clear.
  - FLUSH counts FLUSH_CYCLES cycles, then returns to RUN.
  - clear in FLUSH restarts the count.
- dec_ready = rdy_in & state==RUN & !clear & rob_count<ROB_SIZE & (!dec_need_rs | rs_count<RS_SIZE) & (!dec_need_lsb | lsb_count<LSB_SIZE).
- Issue: next edge sets issue_valid=1, issue_tag=tail, issue_rs/lsb latched, tail<=tail+1 (wraps mod ROB_SIZE). Increments rob_count, plus rs_count/lsb_count when needed. Latency 1 cycle.
- No issue: issue_valid=0 on next enabled edge.
- rob_commit: head<=head+1, rob_count-1.
- rs_release / lsb_release: matching count -1.
- Same-cycle increment and decrement of one counter leaves it unchanged. This permits issue at full when commit is simultaneous only via the count: dec_ready still uses the registered count, so no issue at full.
- Decrement with count 0: ignored, count stays 0.
- clear (RUN or FLUSH, rdy_in=1): takes priority over all.
  - Next edge: tail=head=0, all counts 0, issue_valid=0.
  - commit/release inputs in that cycle and during FLUSH are ignored.
- rdy_in=0: every register holds, including issue_valid. dec_ready=0. Async reset still applies.
- rob_count==ROB_SIZE implies tail==head.

Optional Feature:
Macro DISPATCH_PERF_EN.
- Defined: adds outputs perf_issued[31:0] and perf_stall[31:0], both reset 0.
  - perf_issued counts issues.
  - perf_stall counts cycles with rdy_in & RUN & dec_valid & !dec_ready.
  - Both saturate at all-ones and are not cleared by clear.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package dispatch_pkg: ROB_WIDTH/ROB_SIZE defaults, FSM state enum {RUN, FLUSH}, and the decoder op encodings already used across the core.
- One natural sub-module: credit_counter, an up/down counter with a full flag, ignore-at-zero and synchronous clear. Instantiated three times (ROB, RS, LSB).

Test Plan:
- Reset: rst_in low mid-issue -> all outputs 0 immediately; first issue after release gets issue_tag=0.
- ROB fill: 16 back-to-back issues (need_rs=1, no RS releases, RS_SIZE=8):
  - 8 issues, tags 0..7, then dec_ready=0 with rs_count=8.
  - rs_release -> next issue tag 8.
- Tag wrap: 16 issues each followed by commit -> tags 0..15 then 0; rob_count never exceeds 1.
- Simultaneous events:
  - rob_count=16 with rob_commit -> count 15 next cycle; dec_ready=1 only after that.
  - Issue plus commit with count 5 -> stays 5.
- Flush: clear with rob_count=7, rs_count=3 -> next cycle all counts 0, flushing=1 for 2 cycles, dec_ready=0, releases ignored; then issue_tag=0.
- Freeze: rdy_in=0 for 3 cycles with dec_valid=1 and rob_commit=1 -> no count/tag change, issue_valid held; resumes exactly where it stopped.
